// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: state encoding, default
// sizing and the hold-counter width helper.
package sweep_pkg;

  // Hold counter width: $clog2(hold), never narrower than one bit.
  function automatic int unsigned hold_width(input int unsigned hold);
    if (hold < 2) return 1;
    return $clog2(hold);
  endfunction

  localparam int unsigned N_IN_DEF = 3;
  localparam int unsigned HOLD_DEF = 4;
  localparam int unsigned NUM_VEC  = 2 ** N_IN_DEF;
  localparam int unsigned HOLD_W   = hold_width(HOLD_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

  // Plain constants used by the state register.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/hold_timer.sv
// Counts 0..HOLD-1 while enabled and flags the final cycle of each window.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force the count back to 0 (takes priority over en)
//   en         : advance the count this cycle
//   last       : registered, high while the count equals HOLD-1
module hold_timer
  import sweep_pkg::*;
#(
  parameter int unsigned HOLD = HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int unsigned W = hold_width(HOLD);
  localparam logic [W-1:0] CNT_TOP = W'(HOLD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         last_d;

  // Next count; last is derived from the next count so it stays aligned
  // with the registered count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + W'(1);
    end
    last_d = (cnt_d == CNT_TOP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      last  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      last  <= last_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked stimulus-and-capture stage for a small combinational gate block.
// Walks vec_out through 0..2^N_IN-1, holding each vector HOLD cycles, and
// samples resp_in on the last cycle of each hold window into truth_table.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : one-cycle pulse that begins a sweep (ignored while busy)
//   vec_out     : vector to the gate; MSB -> a, LSB -> c
//   vec_valid   : vec_out carries a sweep vector
//   resp_in     : gate output e
//   busy        : sweep in progress
//   done        : sweep complete, held until next accepted start or reset
//   truth_table : bit k = resp_in captured while vec_out == k
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEF,
  parameter int unsigned HOLD = HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  output logic                 vec_valid,
  input  logic                 resp_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_table
);

  localparam int unsigned N_VEC = 2 ** N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(N_VEC - 1);

  if (HOLD < 2 || HOLD > 256) begin : g_bad_hold
    $error("truth_table_sweeper: HOLD must be in 2..256");
  end

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [N_IN-1:0]  idx_q;
  logic [N_IN-1:0]  idx_d;
  logic [N_IN-1:0]  vec_d;
  logic             vec_valid_d;
  logic             busy_d;
  logic             done_d;
  logic [N_VEC-1:0] table_d;
  logic             timer_clear_c;
  logic             hold_last;

  hold_timer #(.HOLD(HOLD)) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear_c),
    .en    (state_q == ST_DRIVE),
    .last  (hold_last)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    vec_d         = vec_out;
    vec_valid_d   = vec_valid;
    busy_d        = busy;
    done_d        = done;
    table_d       = truth_table;
    timer_clear_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_DRIVE;
          idx_d         = '0;
          vec_d         = '0;
          vec_valid_d   = 1'b1;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          table_d       = '0;
          timer_clear_c = 1'b1;
        end
      end

      ST_DRIVE: begin
        // Capture only at the end of the window, after HOLD-1 settle cycles.
        if (hold_last) begin
          table_d[idx_q] = resp_in;
          if (idx_q == IDX_LAST) begin
            state_d     = ST_DONE;
            idx_d       = '0;
            vec_d       = '0;
            vec_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d = idx_q + N_IN'(1);
            vec_d = idx_q + N_IN'(1);
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        idx_d       = '0;
        vec_d       = '0;
        vec_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        table_d     = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      vec_out     <= '0;
      vec_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vec_out     <= vec_d;
      vec_valid   <= vec_valid_d;
      busy        <= busy_d;
      done        <= done_d;
      truth_table <= table_d;
    end
  end

endmodule
